// File: rtl/data_mem_slave.sv
// data_mem_slave: responder end of the core data-memory bus (req/gnt/rvalid).
// Single-port, word-organised data RAM with byte-enabled writes, a registered
// read path and a programmable number of grant wait states (GNT_WAIT).
// Optional feature macro: DATA_MEM_ERR_EN adds data_err_o and rejects
// accesses whose address lies above the RAM (no write, rdata=0, err=1).
// Without it the upper address bits are ignored and addresses alias.
module data_mem_slave #(
    parameter int WORD_SIZE = 32,
    parameter int MEM_WORDS = 1024,
    parameter int GNT_WAIT  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 data_req_i,
    input  logic [WORD_SIZE-1:0] data_addr_i,
    input  logic                 data_we_i,
    input  logic [3:0]           data_be_i,
    input  logic [WORD_SIZE-1:0] data_wdata_i,
    output logic                 data_gnt_o,
    output logic                 data_rvalid_o,
    output logic [WORD_SIZE-1:0] data_rdata_o
`ifdef DATA_MEM_ERR_EN
    ,
    output logic                 data_err_o
`endif
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = (GNT_WAIT > 0) ? $clog2(GNT_WAIT + 1) : 1;

    // Elaboration-time parameter legality checks
    generate
        if (WORD_SIZE != 32) begin : g_bad_word_size
            $error("data_mem_slave: WORD_SIZE must be 32");
        end
        if ((MEM_WORDS < 2) || ((MEM_WORDS & (MEM_WORDS - 1)) != 0)) begin : g_bad_depth
            $error("data_mem_slave: MEM_WORDS must be a power of two >= 2");
        end
        if (GNT_WAIT < 0) begin : g_bad_wait
            $error("data_mem_slave: GNT_WAIT must be >= 0");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic                  r_rvalid;
    logic [WORD_SIZE-1:0]  r_rdata;
    logic [WORD_SIZE-1:0]  r_mem [MEM_WORDS];

    logic                  w_grant;
    logic [AW-1:0]         w_idx;
    logic                  w_addr_err;
    logic                  w_unused_addr;

    // Word index; the byte offset is never used, lanes come from data_be_i
    assign w_idx = data_addr_i[AW+1:2];

    // Address bits that do not select a word are only consumed by the error check
    assign w_unused_addr = ^{data_addr_i[1:0], data_addr_i[WORD_SIZE-1:AW+2]};

`ifdef DATA_MEM_ERR_EN
    logic r_err;

    // Any set bit above the RAM range marks the access as out of range
    assign w_addr_err = |data_addr_i[WORD_SIZE-1:AW+2];
    assign data_err_o = r_err;

    // Error flag accompanies the response of an out-of-range access only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_grant && w_addr_err;
        end
    end
`else
    assign w_addr_err = 1'b0;
`endif

    // Grant: same-cycle with no wait states, otherwise after GNT_WAIT held cycles
    generate
        if (GNT_WAIT == 0) begin : g_gnt_direct
            assign w_grant = data_req_i && rst_n;
        end else begin : g_gnt_wait
            assign w_grant = data_req_i && rst_n && (r_state == WAIT) &&
                             (r_cnt == CW'(GNT_WAIT));
        end
    endgenerate

    assign data_gnt_o    = w_grant;
    assign data_rvalid_o = r_rvalid;
    assign data_rdata_o  = r_rdata;

    // Wait-state FSM: counts held request cycles, restarts after every grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (GNT_WAIT > 0 && data_req_i) begin
                        r_state <= WAIT;
                        r_cnt   <= CW'(1);
                    end
                end
                WAIT: begin
                    if (!data_req_i) begin
                        // Request withdrawn before grant: abandon without access
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CW'(GNT_WAIT)) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Response path: rvalid follows every grant, rdata updates on reads only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_grant;
            if (w_grant && w_addr_err) begin
                r_rdata <= '0;
            end else if (w_grant && !data_we_i) begin
                r_rdata <= r_mem[w_idx];
            end
        end
    end

    // RAM write port: per-lane byte enables, contents intentionally not reset
    always_ff @(posedge clk) begin
        if (w_grant && data_we_i && !w_addr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_slave.sv
// Directed testbench for data_mem_slave: one instance with same-cycle grant
// and one with two grant wait states, sharing clock and reset.
module tb_data_mem_slave;

    logic        clk;
    logic        rst_n;

    logic        req0, we0;
    logic [31:0] addr0, wdata0;
    logic [3:0]  be0;
    logic        gnt0, rvalid0;
    logic [31:0] rdata0;

    logic        req2, we2;
    logic [31:0] addr2, wdata2;
    logic [3:0]  be2;
    logic        gnt2, rvalid2;
    logic [31:0] rdata2;

`ifdef DATA_MEM_ERR_EN
    logic        err0, err2;
`endif

    int total;
    int bad;

    data_mem_slave #(.WORD_SIZE(32), .MEM_WORDS(1024), .GNT_WAIT(0)) u_dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_req_i   (req0),
        .data_addr_i  (addr0),
        .data_we_i    (we0),
        .data_be_i    (be0),
        .data_wdata_i (wdata0),
        .data_gnt_o   (gnt0),
        .data_rvalid_o(rvalid0),
        .data_rdata_o (rdata0)
`ifdef DATA_MEM_ERR_EN
        ,
        .data_err_o   (err0)
`endif
    );

    data_mem_slave #(.WORD_SIZE(32), .MEM_WORDS(1024), .GNT_WAIT(2)) u_dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_req_i   (req2),
        .data_addr_i  (addr2),
        .data_we_i    (we2),
        .data_be_i    (be2),
        .data_wdata_i (wdata2),
        .data_gnt_o   (gnt2),
        .data_rvalid_o(rvalid2),
        .data_rdata_o (rdata2)
`ifdef DATA_MEM_ERR_EN
        ,
        .data_err_o   (err2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge, drive dut0 inputs, settle 1ns
    task automatic cyc0(input logic req, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
        @(posedge clk);
        #1;
        req0 = req; we0 = we; addr0 = addr; be0 = be; wdata0 = wd;
        #1;
    endtask

    task automatic cyc2(input logic req, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
        @(posedge clk);
        #1;
        req2 = req; we2 = we; addr2 = addr; be2 = be; wdata2 = wd;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = '0; be0 = 4'hF; wdata0 = '0;
        req2 = 1'b1; we2 = 1'b0; addr2 = '0; be2 = 4'hF; wdata2 = '0;
        #1 rst_n = 1'b0;
        #2;
        // Reset state: grant forced low even with a request present
        chk("rst_gnt0",    {31'd0, gnt0},    32'd0);
        chk("rst_gnt2",    {31'd0, gnt2},    32'd0);
        chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("rst_rdata0",  rdata0,           32'd0);
        chk("rst_rvalid2", {31'd0, rvalid2}, 32'd0);
`ifdef DATA_MEM_ERR_EN
        chk("rst_err0",    {31'd0, err0},    32'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req2 = 1'b0;
        rst_n = 1'b1;

        // ---- GNT_WAIT=0: write then back-to-back read ----
        cyc0(1, 1, 32'h10, 4'hF, 32'hDEADBEEF);
        chk("w0_gnt",    {31'd0, gnt0},    32'd1);
        chk("w0_rvalid", {31'd0, rvalid0}, 32'd0);
        cyc0(1, 0, 32'h10, 4'h0, 32'h0);
        chk("r0_gnt",    {31'd0, gnt0},    32'd1);
        chk("w0_resp",   {31'd0, rvalid0}, 32'd1);
        cyc0(0, 0, 32'h0, 4'h0, 32'h0);
        chk("idle_gnt",  {31'd0, gnt0},    32'd0);
        chk("r0_resp",   {31'd0, rvalid0}, 32'd1);
        chk("r0_rdata",  rdata0,           32'hDEADBEEF);
        cyc0(0, 0, 32'h0, 4'h0, 32'h0);
        chk("idle_rvalid", {31'd0, rvalid0}, 32'd0);

        // ---- Byte enables ----
        cyc0(1, 1, 32'h20, 4'hF, 32'h11223344);
        cyc0(1, 1, 32'h20, 4'h5, 32'hAABBCCDD);
        cyc0(1, 0, 32'h20, 4'h0, 32'h0);
        cyc0(1, 1, 32'h20, 4'h0, 32'hFFFFFFFF);
        chk("be5_rdata", rdata0, 32'h11BB33DD);
        cyc0(1, 0, 32'h23, 4'h0, 32'h0);
        chk("be0_rvalid", {31'd0, rvalid0}, 32'd1);
        chk("be0_hold",   rdata0,           32'h11BB33DD);
        cyc0(0, 0, 32'h0, 4'h0, 32'h0);
        chk("be0_unchanged", rdata0, 32'h11BB33DD);

        // ---- Reset right after a granted write ----
        cyc0(1, 1, 32'h40, 4'hF, 32'h55AA55AA);
        chk("rw_gnt", {31'd0, gnt0}, 32'd1);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rvalid", {31'd0, rvalid0}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_rvalid", {31'd0, rvalid0}, 32'd0);
        cyc0(1, 0, 32'h40, 4'hF, 32'h0);
        chk("post_rst_rvalid2", {31'd0, rvalid0}, 32'd0);
        cyc0(0, 0, 32'h0, 4'h0, 32'h0);
        chk("rst_keep_rdata", rdata0, 32'h55AA55AA);

        // ---- Out-of-range / aliasing access ----
        cyc0(1, 1, 32'h0, 4'hF, 32'hCAFEF00D);
        cyc0(1, 1, 32'h1000, 4'hF, 32'h12345678);
        chk("oor_gnt", {31'd0, gnt0}, 32'd1);
        cyc0(1, 0, 32'h0, 4'hF, 32'h0);
        chk("oor_rvalid", {31'd0, rvalid0}, 32'd1);
`ifdef DATA_MEM_ERR_EN
        chk("oor_err",   {31'd0, err0}, 32'd1);
        chk("oor_rdata", rdata0,        32'd0);
`endif
        cyc0(0, 0, 32'h0, 4'h0, 32'h0);
`ifdef DATA_MEM_ERR_EN
        chk("w0_intact", rdata0,        32'hCAFEF00D);
        chk("err_clear", {31'd0, err0}, 32'd0);
`else
        chk("alias_w0",  rdata0,        32'h12345678);
`endif

        // ---- GNT_WAIT=2: held write then held read ----
        cyc2(1, 1, 32'h8, 4'hF, 32'h0BADF00D);
        chk("gw_c0_gnt", {31'd0, gnt2}, 32'd0);
        cyc2(1, 1, 32'h8, 4'hF, 32'h0BADF00D);
        chk("gw_c1_gnt", {31'd0, gnt2}, 32'd0);
        cyc2(1, 1, 32'h8, 4'hF, 32'h0BADF00D);
        chk("gw_c2_gnt", {31'd0, gnt2}, 32'd1);
        chk("gw_c2_rvalid", {31'd0, rvalid2}, 32'd0);
        cyc2(1, 0, 32'h8, 4'hF, 32'h0);
        chk("gw_c3_rvalid", {31'd0, rvalid2}, 32'd1);
        chk("gw_c3_gnt",    {31'd0, gnt2},    32'd0);
        cyc2(1, 0, 32'h8, 4'hF, 32'h0);
        chk("gw_c4_gnt",    {31'd0, gnt2},    32'd0);
        chk("gw_c4_rvalid", {31'd0, rvalid2}, 32'd0);
        cyc2(1, 0, 32'h8, 4'hF, 32'h0);
        chk("gw_c5_gnt",    {31'd0, gnt2},    32'd1);
        cyc2(0, 0, 32'h0, 4'h0, 32'h0);
        chk("gw_c6_rvalid", {31'd0, rvalid2}, 32'd1);
        chk("gw_c6_rdata",  rdata2,           32'h0BADF00D);
        cyc2(0, 0, 32'h0, 4'h0, 32'h0);
        chk("gw_c7_rvalid", {31'd0, rvalid2}, 32'd0);

        // ---- GNT_WAIT=2: request withdrawn, then a fresh request ----
        cyc2(1, 0, 32'h8, 4'hF, 32'h0);
        chk("drop_c0_gnt", {31'd0, gnt2}, 32'd0);
        cyc2(0, 0, 32'h0, 4'h0, 32'h0);
        chk("drop_c1_gnt", {31'd0, gnt2}, 32'd0);
        cyc2(0, 0, 32'h0, 4'h0, 32'h0);
        chk("drop_c2_rvalid", {31'd0, rvalid2}, 32'd0);
        cyc2(1, 0, 32'h8, 4'hF, 32'h0);
        chk("drop_c3_gnt", {31'd0, gnt2}, 32'd0);
        chk("drop_c3_rvalid", {31'd0, rvalid2}, 32'd0);
        cyc2(1, 0, 32'h8, 4'hF, 32'h0);
        chk("drop_c4_gnt", {31'd0, gnt2}, 32'd0);
        cyc2(1, 0, 32'h8, 4'hF, 32'h0);
        chk("drop_c5_gnt", {31'd0, gnt2}, 32'd1);
        cyc2(0, 0, 32'h0, 4'h0, 32'h0);
        chk("drop_c6_rvalid", {31'd0, rvalid2}, 32'd1);
        chk("drop_c6_rdata",  rdata2,           32'h0BADF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
